guess_evaluator: RTL and testbench
==================================

Name: guess_evaluator

Overview:
- Consumes a submitted guess row from the letter-selection stage and scores it against the secret word using Wordle rules: green = right letter, right place; yellow = present elsewhere; gray = absent.
- Handles duplicate letters with a two-pass, consume-once algorithm.
- Tracks the guess count, win and game-over status.
- Feeds per-tile colour codes to the VGA grid renderer.

Parameters:
- WORD_LEN, 5, letters per word/row.
- LETTER_W, 5, bits per letter code (A=0 … Z=25).
- MAX_GUESSES, 6, rows available before loss.

Ports:
- clk  input  1  system clock.
- clr  input  1  synchronous, active-high reset.
- new_game  input  1  clears count/win/game_over; honoured only in IDLE.
- start  input  1  single-cycle submit pulse from the selection stage.
- guess  input  WORD_LEN*LETTER_W  guess letters; position i = guess[LETTER_W*i +: LETTER_W]; position 0 is leftmost.
- secret  input  WORD_LEN*LETTER_W  secret word, same packing; sampled with start.
- busy  output  1  high while evaluating.
- done  output  1  one-cycle pulse when result is valid.
- result  output  2*WORD_LEN  colour of position i at result[2i+1:2i]: 00 gray, 01 yellow, 10 green, 11 unused.
- win  output  1  sticky; last scored guess was all green.
- game_over  output  1  sticky; win or MAX_GUESSES guesses scored.
- guess_count  output  3  number of guesses scored (0..MAX_GUESSES).
- invalid  output  1  see Optional Feature.

Behaviour:
- Reset (clr high at a clk edge):
  - state=IDLE.
  - busy, done, result, win, game_over, guess_count, invalid all 0.
  - Internal guess/secret copies, avail mask and index cleared.
  - clr overrides everything, including mid-evaluation; no done is produced for an aborted guess.
- IDLE:
  - start=1 and game_over=0: latch guess and secret, clear result, idx=0, busy=1, go to GREEN.
  - start while game_over=1: ignored.
  - new_game=1 (takes priority over start in the same cycle): clears guess_count, win, game_over; no evaluation.
- GREEN, one position per cycle, idx 0..WORD_LEN-1:
  - If g[idx]==s[idx]: result[idx]=10, avail[idx]=0.
  - Else: avail[idx]=1.
  - After idx=WORD_LEN-1: idx=0, go to YELLOW.
- YELLOW, one position per cycle:
  - If result[idx]!=10: find the lowest j with avail[j]=1 and s[j]==g[idx]. If found, result[idx]=01 and avail[j]=0; otherwise result stays 00.
  - The search is combinational within the cycle.
  - After the last position, go to DONE.
- DONE, one cycle:
  - done=1, busy=0.
  - guess_count increments.
  - win=1 if every position is 10.
  - game_over=1 if win, or if the new guess_count==MAX_GUESSES.
  - Return to IDLE.
- Latency: start sampled at edge 0 → done high during cycle 2*WORD_LEN+1 (11 for the default). busy is high for cycles 1..2*WORD_LEN.
- start or new_game while busy: ignored, not queued.
- result holds its value until the next accepted start or clr.
- guess_count saturates at MAX_GUESSES; it cannot wrap because game_over blocks further starts.

Optional Feature:
- Macro: GUESS_EVALUATOR_VALID_CHECK_EN.
- Enabled:
  - In IDLE on an accepted start, if any letter code is >25 (blank or invalid tile), skip evaluation entirely.
  - Next cycle: done=1, invalid=1 for one cycle, result=0, guess_count/win/game_over unchanged.
  - invalid is 0 on every normal done.
- Disabled: invalid tied to 0; codes >25 are compared like any other value.

Test Plan:
- secret APPLE(0,15,15,11,4), guess PAPER(15,0,15,4,17) → done 11 cycles after start, result=10'h065, win=0, guess_count=1.
- secret APPLE, guess PPPPP → result=10'h028 (only positions 1,2 green; no yellows from consumed P's).
- secret APPLE, guess APPLE → result=10'h2AA, win=1, game_over=1; a further start produces no busy and no done.
- Six non-matching guesses → game_over=1 after the 6th done, guess_count=6, win=0. 7th start ignored. new_game → count=0, game_over=0.
- Assert clr at cycle 5 of an evaluation → all outputs 0 next cycle, no done. Fresh start then evaluates normally. A start pulsed while busy is ignored.
- With GUESS_EVALUATOR_VALID_CHECK_EN: guess containing code 31 → done and invalid on cycle 1, result=0, guess_count unchanged. Without the macro: same guess takes 11 cycles, invalid=0.

Source files
------------

// File: rtl/guess_evaluator_if.sv
// Submit/score bundle between the letter-selection stage, the evaluator and the grid renderer.
// Latency: none, wires only.
// Backpressure: none; start is dropped by the evaluator unless it is idle and the game is live.
interface guess_evaluator_if #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
);
  logic                         new_game;
  logic                         start;
  logic [WORD_LEN*LETTER_W-1:0] guess;
  logic [WORD_LEN*LETTER_W-1:0] secret;
  logic                         busy;
  logic                         done;
  logic [2*WORD_LEN-1:0]        result;
  logic                         win;
  logic                         game_over;
  logic [2:0]                   guess_count;
  logic                         invalid;

  // Evaluator side
  modport slave (
    input  new_game, start, guess, secret,
    output busy, done, result, win, game_over, guess_count, invalid
  );

  // Selection stage / renderer side
  modport master (
    output new_game, start, guess, secret,
    input  busy, done, result, win, game_over, guess_count, invalid
  );
endinterface

// File: rtl/guess_evaluator.sv
// Wordle row scorer: green pass then consume-once yellow pass, plus guess count / win / game-over tracking.
// Latency: start at edge 0 -> done pulse in cycle 2*WORD_LEN+1; busy in cycles 1..2*WORD_LEN.
// Backpressure: start/new_game outside IDLE are dropped, not queued. Optional macro GUESS_EVALUATOR_VALID_CHECK_EN rejects rows with codes >25.
module guess_evaluator #(
  parameter int WORD_LEN    = 5,
  parameter int LETTER_W    = 5,
  parameter int MAX_GUESSES = 6
) (
  input  logic              clk,
  input  logic              clr,
  guess_evaluator_if.slave  ev
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam int ROW_W = WORD_LEN * LETTER_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_GUESSES);

  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      g_q, g_d;
  logic [ROW_W-1:0]      s_q, s_d;
  logic [WORD_LEN-1:0]   avail_q, avail_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2*WORD_LEN-1:0] result_q, result_d;
  logic                  win_q, win_d;
  logic                  over_q, over_d;
  logic [2:0]            count_q, count_d;
  logic                  invalid_q, invalid_d;

  logic [LETTER_W-1:0]   g_let [WORD_LEN];
  logic [LETTER_W-1:0]   s_let [WORD_LEN];
  logic                  accept;
  logic                  bad_row;
  logic                  last_pos;
  logic                  hit;
  logic [IDX_W-1:0]      hit_j;
  logic                  all_green;

  assign accept   = (state_q == S_IDLE) && ev.start && !ev.new_game && !over_q;
  assign last_pos = (idx_q == LAST_IDX);

`ifdef GUESS_EVALUATOR_VALID_CHECK_EN
  // Flag a submitted row holding any code beyond Z (blank or garbage tile)
  always_comb begin
    bad_row = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (ev.guess[LETTER_W*i +: LETTER_W] > LETTER_W'(25)) bad_row = 1'b1;
    end
  end
`else
  assign bad_row = 1'b0;
`endif

  // Split the latched rows into per-position letters
  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      g_let[i] = g_q[LETTER_W*i +: LETTER_W];
      s_let[i] = s_q[LETTER_W*i +: LETTER_W];
    end
  end

  // Lowest still-available secret position matching the current guess letter
  always_comb begin
    hit   = 1'b0;
    hit_j = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (avail_q[j] && (s_let[j] == g_let[idx_q])) begin
        hit   = 1'b1;
        hit_j = IDX_W'(j);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: walk all positions for greens, then all for yellows, then one done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = bad_row ? S_DONE : S_GREEN;
      S_GREEN:  if (last_pos) state_d = S_YELLOW;
      S_YELLOW: if (last_pos) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: scoring, letter consumption and game bookkeeping
  always_comb begin
    g_d       = g_q;
    s_d       = s_q;
    avail_d   = avail_q;
    idx_d     = idx_q;
    result_d  = result_q;
    win_d     = win_q;
    over_d    = over_q;
    count_d   = count_q;
    invalid_d = invalid_q;
    all_green = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev.new_game) begin
          count_d = '0;
          win_d   = 1'b0;
          over_d  = 1'b0;
        end else if (accept) begin
          g_d       = ev.guess;
          s_d       = ev.secret;
          avail_d   = '0;
          idx_d     = '0;
          result_d  = '0;
          invalid_d = bad_row;
        end
      end
      S_GREEN: begin
        if (g_let[idx_q] == s_let[idx_q]) begin
          result_d[2*idx_q +: 2] = 2'b10;
          avail_d[idx_q]         = 1'b0;
        end else begin
          avail_d[idx_q] = 1'b1;
        end
        idx_d = last_pos ? '0 : idx_q + 1'b1;
      end
      S_YELLOW: begin
        if ((result_q[2*idx_q +: 2] != 2'b10) && hit) begin
          result_d[2*idx_q +: 2] = 2'b01;
          avail_d[hit_j]         = 1'b0;
        end
        idx_d = last_pos ? '0 : idx_q + 1'b1;
        // Publish the game status together with the done pulse
        if (last_pos) begin
          all_green = 1'b1;
          for (int i = 0; i < WORD_LEN; i++) begin
            if (result_d[2*i +: 2] != 2'b10) all_green = 1'b0;
          end
          if (count_q < MAX_CNT) count_d = count_q + 3'd1;
          win_d  = all_green;
          over_d = all_green || (count_d == MAX_CNT);
        end
      end
      S_DONE: invalid_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers; clr aborts any evaluation in flight
  always_ff @(posedge clk) begin
    if (clr) begin
      g_q       <= '0;
      s_q       <= '0;
      avail_q   <= '0;
      idx_q     <= '0;
      result_q  <= '0;
      win_q     <= 1'b0;
      over_q    <= 1'b0;
      count_q   <= '0;
      invalid_q <= 1'b0;
    end else begin
      g_q       <= g_d;
      s_q       <= s_d;
      avail_q   <= avail_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      win_q     <= win_d;
      over_q    <= over_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
    end
  end

  // Outputs decoded from state plus registered status
  always_comb begin
    ev.busy        = (state_q == S_GREEN) || (state_q == S_YELLOW);
    ev.done        = (state_q == S_DONE);
    ev.result      = result_q;
    ev.win         = win_q;
    ev.game_over   = over_q;
    ev.guess_count = count_q;
    ev.invalid     = invalid_q;
  end

endmodule

// File: tb/tb_guess_evaluator.sv
module tb_guess_evaluator;
  localparam int WL   = 5;
  localparam int LW   = 5;
  localparam int MAXG = 6;
  localparam int ROW  = WL * LW;
  localparam logic [2*WL-1:0] ALLG = 10'h2AA;
`ifdef GUESS_EVALUATOR_VALID_CHECK_EN
  localparam bit VCHK = 1'b1;
`else
  localparam bit VCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  guess_evaluator_if #(.WORD_LEN(WL), .LETTER_W(LW)) ev();

  guess_evaluator #(.WORD_LEN(WL), .LETTER_W(LW), .MAX_GUESSES(MAXG)) u_dut (
    .clk (clk),
    .clr (clr),
    .ev  (ev.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW-1:0] word(input int l0, l1, l2, l3, l4);
    logic [ROW-1:0] w;
    w = {LW'(l4), LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    return w;
  endfunction

  // Reference Wordle scoring: greens first, then each non-green takes the lowest unused match
  function automatic logic [2*WL-1:0] ref_score(input logic [ROW-1:0] g, input logic [ROW-1:0] s);
    int gl[WL];
    int sl[WL];
    bit used[WL];
    logic [2*WL-1:0] r;
    r = '0;
    for (int i = 0; i < WL; i++) begin
      gl[i] = int'(g[LW*i +: LW]);
      sl[i] = int'(s[LW*i +: LW]);
      used[i] = 1'b0;
    end
    for (int i = 0; i < WL; i++)
      if (gl[i] == sl[i]) begin r[2*i +: 2] = 2'b10; used[i] = 1'b1; end
    for (int i = 0; i < WL; i++) begin
      if (r[2*i +: 2] != 2'b10) begin
        for (int j = 0; j < WL; j++) begin
          if (!used[j] && sl[j] == gl[i]) begin
            r[2*i +: 2] = 2'b01;
            used[j] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [ROW-1:0] g);
    bit b;
    b = 1'b0;
    for (int i = 0; i < WL; i++) if (int'(g[LW*i +: LW]) > 25) b = 1'b1;
    return b;
  endfunction

  // Behavioural timeline: cycles of busy left, a done cycle, and the game score
  bit              m_valid = 1'b0;
  int              m_left  = 0;
  bit              m_done, m_inv, m_win, m_over;
  int              m_count;
  logic [2*WL-1:0] m_result, m_pend;

  always @(posedge clk) begin
    if (clr) begin
      m_valid = 1'b1; m_left = 0; m_done = 1'b0; m_inv = 1'b0;
      m_win = 1'b0; m_over = 1'b0; m_count = 0; m_result = '0; m_pend = '0;
    end else if (!m_valid) begin
      m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_inv  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done   = 1'b1;
        m_result = m_pend;
        m_win    = (m_pend == ALLG);
        if (m_count < MAXG) m_count++;
        m_over   = m_win || (m_count == MAXG);
      end
    end else if (ev.new_game) begin
      m_count = 0; m_win = 1'b0; m_over = 1'b0;
    end else if (ev.start && !m_over) begin
      m_result = '0;
      if (VCHK && has_bad(ev.guess)) begin
        m_done = 1'b1;
        m_inv  = 1'b1;
      end else begin
        m_pend = ref_score(ev.guess, ev.secret);
        m_left = 2 * WL;
      end
    end
  end

  // Compare every cycle; result is only meaningful once evaluation has finished
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",        ev.busy,        m_left > 0);
      chk("done",        ev.done,        m_done);
      chk("invalid",     ev.invalid,     m_inv);
      chk("guess_count", ev.guess_count, m_count);
      chk("win",         ev.win,         m_win);
      chk("game_over",   ev.game_over,   m_over);
      if (m_left == 0) chk("result", ev.result, m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ROW-1:0] g, input logic [ROW-1:0] s);
    ev.guess  = g;
    ev.secret = s;
    ev.start  = 1'b1;
    tick();
    ev.start  = 1'b0;
  endtask

  task automatic pulse_new_game();
    ev.new_game = 1'b1;
    tick();
    ev.new_game = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; 40 means it never came
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ev.done === 1'b1) break;
    end
  endtask

  // Watch a window and report how many cycles showed busy or done
  task automatic watch_quiet(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ev.busy === 1'b1 || ev.done === 1'b1) seen++;
    end
  endtask

  logic [ROW-1:0] apple, paper, ppppp, zzzzz, badrow;
  int n, seen, cnt_before;

  initial begin
    apple  = word(0, 15, 15, 11, 4);
    paper  = word(15, 0, 15, 4, 17);
    ppppp  = word(15, 15, 15, 15, 15);
    zzzzz  = word(25, 25, 25, 25, 25);
    badrow = word(0, 15, 31, 11, 4);

    clr = 1'b1; ev.start = 1'b0; ev.new_game = 1'b0; ev.guess = '0; ev.secret = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy",  ev.busy, 0);
    chk("rst_done",  ev.done, 0);
    chk("rst_res",   ev.result, 0);
    chk("rst_count", ev.guess_count, 0);
    chk("rst_over",  ev.game_over, 0);
    tick();
    clr = 1'b0;

    // Pin the reference model against hand-scored rows
    chk("model_paper", ref_score(paper, apple), 10'h065);
    chk("model_ppppp", ref_score(ppppp, apple), 10'h028);
    chk("model_apple", ref_score(apple, apple), 10'h2AA);

    pulse_start(paper, apple);
    wait_done(n);
    chk("lat_paper",   n, 11);
    chk("res_paper",   ev.result, 10'h065);
    chk("win_paper",   ev.win, 0);
    chk("count_paper", ev.guess_count, 1);
    tick();

    pulse_start(ppppp, apple);
    wait_done(n);
    chk("res_ppppp", ev.result, 10'h028);
    tick();

    pulse_start(apple, apple);
    wait_done(n);
    chk("res_apple",  ev.result, 10'h2AA);
    chk("win_apple",  ev.win, 1);
    chk("over_apple", ev.game_over, 1);
    tick();
    pulse_start(paper, apple);
    watch_quiet(15, seen);
    chk("start_after_win", seen, 0);
    tick();

    pulse_new_game();
    @(negedge clk);
    chk("ng_count", ev.guess_count, 0);
    chk("ng_over",  ev.game_over, 0);
    tick();
    for (int k = 0; k < MAXG; k++) begin
      pulse_start(zzzzz, apple);
      wait_done(n);
      chk("lat_loss", n, 11);
      tick();
    end
    chk("loss_count", ev.guess_count, 6);
    chk("loss_over",  ev.game_over, 1);
    chk("loss_win",   ev.win, 0);
    pulse_start(paper, apple);
    watch_quiet(15, seen);
    chk("start_after_loss", seen, 0);
    tick();
    pulse_new_game();
    @(negedge clk);
    chk("ng2_count", ev.guess_count, 0);
    chk("ng2_over",  ev.game_over, 0);
    tick();

    // Abort mid-evaluation with clr
    pulse_start(paper, apple);
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("abort_busy",  ev.busy, 0);
    chk("abort_done",  ev.done, 0);
    chk("abort_res",   ev.result, 0);
    chk("abort_count", ev.guess_count, 0);
    watch_quiet(14, seen);
    chk("abort_no_done", seen, 0);
    tick();

    // Fresh start, with a second start pulsed while busy
    pulse_start(paper, apple);
    repeat (3) tick();
    ev.guess = apple; ev.start = 1'b1;
    tick();
    ev.start = 1'b0;
    wait_done(n);
    chk("lat_busy_start", n + 4, 11);
    chk("res_busy_start", ev.result, 10'h065);
    tick();
    watch_quiet(12, seen);
    chk("busy_start_not_queued", seen, 0);
    tick();

    // Row with an out-of-alphabet code
    cnt_before = int'(ev.guess_count);
    pulse_start(badrow, apple);
    wait_done(n);
    chk("lat_bad",     n, VCHK ? 1 : 11);
    chk("invalid_bad", ev.invalid, VCHK ? 1 : 0);
    chk("count_bad",   ev.guess_count, VCHK ? cnt_before : cnt_before + 1);
    if (VCHK) chk("res_bad", ev.result, 0);
    tick();

    // Randomized play over a small alphabet to force duplicates and wins
    for (int c = 0; c < 3000; c++) begin
      logic [ROW-1:0] s, g;
      for (int i = 0; i < WL; i++) begin
        s[LW*i +: LW] = LW'($urandom_range(0, 3));
        g[LW*i +: LW] = ($urandom_range(0, 15) == 0) ? LW'($urandom_range(26, 31))
                                                      : LW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) g = s;
      ev.secret   = s;
      ev.guess    = g;
      ev.start    = ($urandom_range(0, 3) == 0);
      ev.new_game = ($urandom_range(0, 24) == 0);
      clr         = ($urandom_range(0, 199) == 0);
      tick();
    end
    ev.start = 1'b0; ev.new_game = 1'b0; clr = 1'b0;
    repeat (15) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
